adc_axis_packetizer: RTL and testbench

Downstream stage of the ADC configuration/SPI path. Consumes the free-running ADC sample stream, frames it into fixed-length AXI-Stream packets (asserting `m_axis_tlast` on the final beat), and feeds the DMA engine. Packet length and enable come from the 32-bit `packetizer_cfg` word produced by the AXI-lite configuration block. Completed-packet count and busy flag are returned for the status register.

---
 rtl/adc_axis_packetizer.sv | 168 ++++++++++++++++
 tb/tb_adc_axis_packetizer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/adc_axis_packetizer.sv
// adc_axis_packetizer
// Frames the free-running ADC sample stream into fixed-length AXI-Stream
// packets for the DMA engine. A two-entry {data, last} buffer decouples the
// ADC side from DMA backpressure. The completed-packet count and the busy
// flag are returned to the status register.

module adc_axis_packetizer #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic [31:0]           cfg,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   output logic                  m_axis_tlast,
   input  logic                  m_axis_tready,
   output logic [31:0]           packet_count,
   output logic                  busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [30:0]           len_q, len_d;
   logic [30:0]           beat_q, beat_d;
   logic [1:0]            cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] data0_q, data0_d;
   logic [DATA_WIDTH-1:0] data1_q, data1_d;
   logic                  last0_q, last0_d;
   logic                  last1_q, last1_d;
   logic [31:0]           pkt_cnt_q, pkt_cnt_d;

   logic                  cfg_start;
   logic                  in_ready;
   logic                  wr_en;
   logic                  rd_en;
   logic                  in_last;

   // Handshake decode. Input readiness looks only at the registered entry
   // count, so a full buffer that drains this cycle stays closed until the
   // next cycle. Entry 0 is always the head of the buffer.
   always_comb begin
      cfg_start = cfg[31] && (cfg[30:0] != 31'd0);
      in_ready  = (state_q == IDLE) || ((state_q == RUN) && (cnt_q != 2'd2));
      wr_en     = (state_q == RUN) && s_axis_tvalid && (cnt_q != 2'd2);
      rd_en     = (cnt_q != 2'd0) && m_axis_tready;
      in_last   = (beat_q == (len_q - 31'd1));
   end

   // Outputs are forced to zero while reset is held, independent of the
   // register contents, so nothing partial leaks out during reset.
   always_comb begin
      s_axis_tready = aresetn && in_ready;
      m_axis_tvalid = aresetn && (cnt_q != 2'd0);
      m_axis_tlast  = aresetn && (cnt_q != 2'd0) && last0_q;
      m_axis_tdata  = aresetn ? data0_q : '0;
      packet_count  = pkt_cnt_q;
      busy          = aresetn && ((state_q != IDLE) || (cnt_q != 2'd0));
   end

   // Framing state machine: length and enable are sampled only in IDLE and
   // on the accept of a packet's final beat, so mid-packet cfg writes wait.
   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      beat_d  = beat_q;
      case (state_q)
         IDLE: begin
            if (cfg_start) begin
               len_d   = cfg[30:0];
               beat_d  = 31'd0;
               state_d = RUN;
            end
         end
         RUN: begin
            if (wr_en) begin
               if (in_last) begin
                  beat_d = 31'd0;
                  if (cfg_start) begin
                     len_d = cfg[30:0];
                  end else begin
                     state_d = DRAIN;
                  end
               end else begin
                  beat_d = beat_q + 31'd1;
               end
            end
         end
         DRAIN: begin
            if (cnt_q == 2'd0) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Two-entry shift buffer: a read shifts entry 1 into the head; a write
   // fills the first free slot, or the head when a read empties it together.
   always_comb begin
      cnt_d   = cnt_q;
      data0_d = data0_q;
      data1_d = data1_q;
      last0_d = last0_q;
      last1_d = last1_q;
      if (wr_en && rd_en) begin
         data0_d = s_axis_tdata;
         last0_d = in_last;
      end else if (wr_en) begin
         cnt_d = cnt_q + 2'd1;
         if (cnt_q == 2'd0) begin
            data0_d = s_axis_tdata;
            last0_d = in_last;
         end else begin
            data1_d = s_axis_tdata;
            last1_d = in_last;
         end
      end else if (rd_en) begin
         cnt_d   = cnt_q - 2'd1;
         data0_d = data1_q;
         last0_d = last1_q;
      end
   end

   // Completed packets are counted when the tlast beat leaves on m_axis.
   always_comb begin
      pkt_cnt_d = pkt_cnt_q;
      if (rd_en && last0_q) begin
         pkt_cnt_d = pkt_cnt_q + 32'd1;
      end
   end

   // State register with synchronous active-low reset; buffered data is
   // discarded on reset.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_q   <= IDLE;
         len_q     <= 31'd0;
         beat_q    <= 31'd0;
         cnt_q     <= 2'd0;
         data0_q   <= '0;
         data1_q   <= '0;
         last0_q   <= 1'b0;
         last1_q   <= 1'b0;
         pkt_cnt_q <= 32'd0;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         beat_q    <= beat_d;
         cnt_q     <= cnt_d;
         data0_q   <= data0_d;
         data1_q   <= data1_d;
         last0_q   <= last0_d;
         last1_q   <= last1_d;
         pkt_cnt_q <= pkt_cnt_d;
      end
   end

endmodule

// File: tb/tb_adc_axis_packetizer.sv
// tb_adc_axis_packetizer
// Directed bench for the ADC AXI-Stream packetizer. Inputs change on the
// falling edge and outputs are observed there, half a cycle from the
// capturing rising edge.

module tb_adc_axis_packetizer;

   logic        aclk;
   logic        aresetn;
   logic [31:0] cfg;
   logic [31:0] s_axis_tdata;
   logic        s_axis_tvalid;
   logic        s_axis_tready;
   logic [31:0] m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tlast;
   logic        m_axis_tready;
   logic [31:0] packet_count;
   logic        busy;

   int          check_count = 0;
   int          pass_count  = 0;
   int          fail_count  = 0;
   int          next_sample = 1;
   logic [32:0] out_log[$];

   adc_axis_packetizer #(.DATA_WIDTH(32)) dut (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .cfg           (cfg),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tready (m_axis_tready),
      .packet_count  (packet_count),
      .busy          (busy)
   );

   // Free-running 100 MHz clock.
   initial begin
      aclk = 1'b0;
      forever #5 aclk = ~aclk;
   end

   // Hard stop in case the sequence ever stalls.
   initial begin
      #200000;
      $display("[TB] FAIL timeout observed=running expected=finished");
      $fatal(1, "[TB] simulation timeout");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      check_count++;
      assert (observed === expected) begin
         pass_count++;
      end else begin
         fail_count++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Record the handshakes that the coming rising edge will complete, then
   // move on to the next falling edge.
   task automatic advance();
      if (m_axis_tvalid && m_axis_tready) out_log.push_back({m_axis_tlast, m_axis_tdata});
      if (aresetn && s_axis_tvalid && s_axis_tready) next_sample++;
      @(negedge aclk);
   endtask

   // Offer the next sequential sample for one cycle with the given DMA ready.
   task automatic applyStimulus(input logic sv, input logic mr);
      s_axis_tvalid = sv;
      s_axis_tdata  = 32'(next_sample);
      m_axis_tready = mr;
      advance();
   endtask

   task automatic doReset(input logic [31:0] new_cfg);
      aresetn       = 1'b0;
      s_axis_tvalid = 1'b0;
      m_axis_tready = 1'b1;
      cfg           = 32'd0;
      advance();
      advance();
      aresetn     = 1'b1;
      cfg         = new_cfg;
      next_sample = 1;
      out_log.delete();
      advance();
   endtask

   task automatic checkLog(input string tag, input int exp_n, input logic [31:0] last_mask);
      checkOutput({tag, "_beats"}, 32'(out_log.size()), 32'(exp_n));
      for (int i = 0; i < exp_n && i < out_log.size(); i++) begin
         checkOutput($sformatf("%s_data%0d", tag, i), out_log[i][31:0], 32'(i + 1));
         checkOutput($sformatf("%s_last%0d", tag, i), 32'(out_log[i][32]), 32'(last_mask[i]));
      end
   endtask

   initial begin
      aresetn       = 1'b0;
      cfg           = 32'd0;
      s_axis_tdata  = 32'd0;
      s_axis_tvalid = 1'b0;
      m_axis_tready = 1'b0;

      // Reset: outputs held at zero while aresetn is low.
      #1;
      checkOutput("rst_tready", 32'(s_axis_tready), 32'd0);
      checkOutput("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
      checkOutput("rst_tdata",  m_axis_tdata,       32'd0);
      @(negedge aclk);
      advance();
      checkOutput("rst_pktcnt", packet_count,       32'd0);
      checkOutput("rst_busy",   32'(busy),          32'd0);
      checkOutput("rst_tlast",  32'(m_axis_tlast),  32'd0);

      // Basic framing, N=4, samples 1..12 at full rate.
      doReset(32'h8000_0004);
      checkOutput("frm_busy_run", 32'(busy), 32'd1);
      for (int i = 1; i <= 12; i++) begin
         applyStimulus(1'b1, 1'b1);
         checkOutput($sformatf("frm_tvalid%0d", i), 32'(m_axis_tvalid), 32'd1);
         checkOutput($sformatf("frm_tdata%0d", i), m_axis_tdata, 32'(i));
         checkOutput($sformatf("frm_tlast%0d", i), 32'(m_axis_tlast), 32'((i % 4) == 0));
      end
      applyStimulus(1'b0, 1'b1);
      checkOutput("frm_pktcnt", packet_count, 32'd3);
      checkOutput("frm_empty", 32'(m_axis_tvalid), 32'd0);
      checkLog("frm", 12, 32'h0000_0888);

      // Backpressure, N=4: DMA stalls for 5 cycles after two beats.
      doReset(32'h8000_0004);
      applyStimulus(1'b1, 1'b1);
      applyStimulus(1'b1, 1'b1);
      checkOutput("bp_tready_open", 32'(s_axis_tready), 32'd1);
      for (int k = 0; k < 5; k++) begin
         applyStimulus(1'b1, 1'b0);
         checkOutput($sformatf("bp_tready%0d", k), 32'(s_axis_tready), 32'd0);
         checkOutput($sformatf("bp_hold_data%0d", k), m_axis_tdata, 32'd2);
         checkOutput($sformatf("bp_hold_valid%0d", k), 32'(m_axis_tvalid), 32'd1);
      end
      applyStimulus(1'b1, 1'b1);
      checkOutput("bp_no_reopen", 32'(next_sample), 32'd4);
      checkOutput("bp_reopen_next", 32'(s_axis_tready), 32'd1);
      for (int k = 0; k < 20 && next_sample <= 8; k++) applyStimulus(1'b1, 1'b1);
      checkOutput("bp_all_accepted", 32'(next_sample), 32'd9);
      s_axis_tvalid = 1'b0;
      for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b1);
      checkLog("bp", 8, 32'h0000_0088);
      checkOutput("bp_pktcnt", packet_count, 32'd2);

      // Disable after 3 beats of an N=8 packet: packet completes, then DRAIN.
      doReset(32'h8000_0008);
      for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b1);
      cfg = 32'h0000_0008;
      for (int k = 0; k < 20 && next_sample <= 8; k++) applyStimulus(1'b1, 1'b1);
      checkOutput("dis_all_accepted", 32'(next_sample), 32'd9);
      checkOutput("dis_drain_tready", 32'(s_axis_tready), 32'd0);
      checkOutput("dis_last_beat", m_axis_tdata, 32'd8);
      checkOutput("dis_last_flag", 32'(m_axis_tlast), 32'd1);
      applyStimulus(1'b1, 1'b1);
      checkOutput("dis_busy_drain", 32'(busy), 32'd1);
      checkOutput("dis_empty", 32'(m_axis_tvalid), 32'd0);
      applyStimulus(1'b1, 1'b1);
      checkOutput("dis_busy_idle", 32'(busy), 32'd0);
      checkOutput("dis_idle_tready", 32'(s_axis_tready), 32'd1);
      for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b1);
      checkOutput("dis_discard_valid", 32'(m_axis_tvalid), 32'd0);
      checkLog("dis", 8, 32'h0000_0080);
      checkOutput("dis_pktcnt", packet_count, 32'd1);

      // Length change after beat 1: first packet 4 beats, then 2-beat packets.
      doReset(32'h8000_0004);
      applyStimulus(1'b1, 1'b1);
      cfg = 32'h8000_0002;
      for (int k = 0; k < 20 && next_sample <= 8; k++) applyStimulus(1'b1, 1'b1);
      for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b1);
      checkLog("len", 8, 32'h0000_00A8);
      checkOutput("len_pktcnt", packet_count, 32'd3);

      // Enable with length 0 stays IDLE and discards samples.
      doReset(32'h8000_0000);
      for (int k = 0; k < 4; k++) applyStimulus(1'b1, 1'b1);
      checkOutput("n0_tvalid", 32'(m_axis_tvalid), 32'd0);
      checkOutput("n0_busy", 32'(busy), 32'd0);
      checkOutput("n0_nolog", 32'(out_log.size()), 32'd0);

      // N=1: every beat carries tlast and bumps the packet count.
      cfg = 32'h8000_0001;
      applyStimulus(1'b0, 1'b1);
      for (int k = 1; k <= 3; k++) begin
         applyStimulus(1'b1, 1'b1);
         checkOutput($sformatf("n1_tlast%0d", k), 32'(m_axis_tlast), 32'd1);
         checkOutput($sformatf("n1_pktcnt%0d", k), packet_count, 32'(k - 1));
      end
      applyStimulus(1'b0, 1'b1);
      checkOutput("n1_pktcnt_end", packet_count, 32'd3);

      // Reset with two beats buffered under backpressure.
      doReset(32'h8000_0004);
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0);
      checkOutput("mr_full_tready", 32'(s_axis_tready), 32'd0);
      aresetn = 1'b0;
      applyStimulus(1'b0, 1'b0);
      checkOutput("mr_tvalid", 32'(m_axis_tvalid), 32'd0);
      checkOutput("mr_tdata",  m_axis_tdata,       32'd0);
      checkOutput("mr_tlast",  32'(m_axis_tlast),  32'd0);
      checkOutput("mr_tready", 32'(s_axis_tready), 32'd0);
      checkOutput("mr_busy",   32'(busy),          32'd0);
      checkOutput("mr_pktcnt", packet_count,       32'd0);
      aresetn     = 1'b1;
      next_sample = 1;
      out_log.delete();
      applyStimulus(1'b0, 1'b1);
      for (int k = 0; k < 4; k++) applyStimulus(1'b1, 1'b1);
      applyStimulus(1'b0, 1'b1);
      checkLog("mr", 4, 32'h0000_0008);
      checkOutput("mr_pktcnt_after", packet_count, 32'd1);

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
